// File: rtl/seq_frame_capture.sv
// Serial payload capture after a 1101 sync marker, with a single-entry valid/ready holding register.
// Define SEQ_FRAME_PARITY_EN to append and check a trailing even-parity bit per frame.
module seq_frame_capture #(
  parameter int PAYLOAD_W = 8
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 data_in,
  input  logic                 sync_hit,
  output logic [PAYLOAD_W-1:0] frame_data,
  output logic                 frame_valid,
  input  logic                 frame_ready,
  output logic                 frame_drop,
  output logic                 parity_err
);

  localparam int            CW       = $clog2(PAYLOAD_W + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(PAYLOAD_W);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
`ifdef SEQ_FRAME_PARITY_EN
  localparam logic [1:0] ST_PARITY  = 2'd2;
`endif

  logic [1:0]           r_state, w_state_next;
  logic [CW-1:0]        r_cnt, w_cnt_next;
  logic [PAYLOAD_W-1:0] r_shift;
  logic [PAYLOAD_W:0]   w_shift_ext;
  logic [PAYLOAD_W-1:0] w_frame_word;
  logic                 w_shift_en;
  logic                 w_complete;
  logic                 w_load;
  logic                 w_discard;
  logic [PAYLOAD_W-1:0] r_data;
  logic                 r_valid;
  logic                 r_drop;
`ifdef SEQ_FRAME_PARITY_EN
  logic                 w_frame_perr;
  logic                 r_perr;
`endif

  assign w_shift_ext = {r_shift, data_in};

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_shift_en   = 1'b0;
    w_complete   = 1'b0;
    w_frame_word = w_shift_ext[PAYLOAD_W-1:0];
`ifdef SEQ_FRAME_PARITY_EN
    w_frame_perr = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (sync_hit) begin
          w_shift_en   = 1'b1;
          w_cnt_next   = CNT_ONE;
          w_state_next = ST_CAPTURE;
        end
      end
      ST_CAPTURE: begin
        w_shift_en = 1'b1;
        w_cnt_next = r_cnt + CNT_ONE;
      end
`ifdef SEQ_FRAME_PARITY_EN
      ST_PARITY: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
        w_complete   = 1'b1;
        w_frame_word = r_shift;
        w_frame_perr = ^{r_shift, data_in};
      end
`endif
      default: begin
        w_state_next = ST_IDLE;
        w_cnt_next   = '0;
      end
    endcase

    // The edge that shifts in the last payload bit ends the capture phase (also covers PAYLOAD_W=1).
    if (w_shift_en && (w_cnt_next == CNT_LAST)) begin
`ifdef SEQ_FRAME_PARITY_EN
      w_state_next = ST_PARITY;
`else
      w_state_next = ST_IDLE;
      w_cnt_next   = '0;
      w_complete   = 1'b1;
`endif
    end
  end

  assign w_load    = w_complete && (!r_valid || frame_ready);
  assign w_discard = w_complete && r_valid && !frame_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register sees pre-edge values of the others.
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_shift_en) begin
        r_shift <= w_shift_ext[PAYLOAD_W-1:0];
      end
      r_drop <= w_discard;
      if (w_load) begin
        r_valid <= 1'b1;
        r_data  <= w_frame_word;
      end else if (r_valid && frame_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef SEQ_FRAME_PARITY_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_perr <= 1'b0;
    end else if (w_load) begin
      r_perr <= w_frame_perr;
    end
  end

  assign parity_err = r_perr;
`else
  assign parity_err = 1'b0;
`endif

  assign frame_data  = r_data;
  assign frame_valid = r_valid;
  assign frame_drop  = r_drop;

endmodule

// File: tb/tb_seq_frame_capture.sv
// Scoreboard bench for seq_frame_capture: a bit-collecting reference model predicts frames,
// a negedge monitor compares every handshake plus per-cycle valid/drop flags.
module tb_seq_frame_capture;

  localparam int W = 8;
`ifdef SEQ_FRAME_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif

  typedef struct packed {
    logic [W-1:0] data;
    logic         perr;
  } frame_t;

  logic         clk;
  logic         rstn;
  logic         data_in;
  logic         sync_hit;
  logic [W-1:0] frame_data;
  logic         frame_valid;
  logic         frame_ready;
  logic         frame_drop;
  logic         parity_err;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase 0 = waiting for sync, 1 = collecting payload, 2 = awaiting parity bit.
  int              m_phase = 0;
  int              m_k     = 0;
  longint unsigned m_acc   = 0;
  logic            m_valid = 1'b0;
  logic            m_drop  = 1'b0;
  frame_t          exp_q[$];

  seq_frame_capture #(.PAYLOAD_W(W)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .data_in     (data_in),
    .sync_hit    (sync_hit),
    .frame_data  (frame_data),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready),
    .frame_drop  (frame_drop),
    .parity_err  (parity_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input logic s, input logic d, input logic r);
    logic accept;
    logic done;
    logic perr;
    accept = m_valid && r;
    done   = 1'b0;
    perr   = 1'b0;
    m_drop = 1'b0;
    case (m_phase)
      0: if (s) begin
        m_acc   = longint'(d);
        m_k     = 1;
        m_phase = 1;
      end
      1: begin
        m_acc = (m_acc << 1) | longint'(d);
        m_k++;
      end
      default: begin
        perr    = ((($countones(m_acc) + int'(d)) % 2) == 1);
        done    = 1'b1;
        m_phase = 0;
      end
    endcase
    if (m_phase == 1 && m_k == W) begin
      if (PAR_BITS == 1) begin
        m_phase = 2;
      end else begin
        done    = 1'b1;
        m_phase = 0;
      end
    end
    if (done) begin
      if (!m_valid || accept) begin
        m_valid = 1'b1;
        exp_q.push_back('{data: W'(m_acc), perr: perr});
      end else begin
        m_drop = 1'b1;
      end
    end else if (accept) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_k     = 0;
    m_acc   = 0;
    m_valid = 1'b0;
    m_drop  = 1'b0;
    exp_q.delete();
  endtask

  // Inputs are applied at posedge+1 and consumed by the following posedge.
  task automatic step(input logic s, input logic d, input logic r);
    sync_hit    = s;
    data_in     = d;
    frame_ready = r;
    @(posedge clk);
    if (rstn) model_edge(s, d, r);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] w, input logic par, input logic rdy,
                            input logic rdy_last, input int inject_at);
    int   n;
    logic b;
    n = W + PAR_BITS;
    for (int i = 0; i < n; i++) begin
      b = (i < W) ? w[W-1-i] : par;
      step((i == 0) || (i == inject_at), b, (i == n - 1) ? rdy_last : rdy);
    end
  endtask

  always @(negedge clk) begin
    frame_t e;
    if (rstn) begin
      check("frame_valid", 64'(frame_valid), 64'(m_valid));
      check("frame_drop", 64'(frame_drop), 64'(m_drop));
      if (frame_valid && frame_ready) begin
        check("frame_expected", 64'(exp_q.size() > 0), 64'(1));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("frame_data", 64'(frame_data), 64'(e.data));
          check("parity_err", 64'(parity_err), 64'(e.perr));
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [11:0] stream;
    rstn        = 1'b0;
    sync_hit    = 1'b0;
    data_in     = 1'b0;
    frame_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_frame_valid", 64'(frame_valid), 64'(0));
    check("reset_frame_data", 64'(frame_data), 64'(0));
    check("reset_frame_drop", 64'(frame_drop), 64'(0));
    check("reset_parity_err", 64'(parity_err), 64'(0));
    rstn = 1'b1;
    step(0, 0, 0);

    // Basic capture
    send_frame(8'hA6, 1'b0, 1'b1, 1'b1, -1);
    check("basic_data", 64'(frame_data), 64'(8'hA6));
    check("basic_valid", 64'(frame_valid), 64'(1));
    repeat (3) step(0, 0, 1);

    // Embedded 1101 with a spurious sync during capture
    send_frame(8'hD3, 1'b0, 1'b1, 1'b1, 3);
    check("embedded_data", 64'(frame_data), 64'(8'hD3));
    repeat (W + 3) step(0, 0, 1);
    check("embedded_no_restart", 64'(frame_valid), 64'(0));

    // Back-pressure and drop
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, -1);
    send_frame(8'h34, 1'b0, 1'b0, 1'b0, -1);
    check("bp_held_data", 64'(frame_data), 64'(8'h12));
    check("bp_drop_pulse", 64'(frame_drop), 64'(1));
    step(0, 0, 1);
    check("bp_drained", 64'(frame_valid), 64'(0));
    step(0, 0, 0);

    // Simultaneous drain and load
    send_frame(8'h12, 1'b0, 1'b0, 1'b0, -1);
    send_frame(8'h34, 1'b0, 1'b0, 1'b1, -1);
    check("sim_data", 64'(frame_data), 64'(8'h34));
    check("sim_valid", 64'(frame_valid), 64'(1));
    check("sim_no_drop", 64'(frame_drop), 64'(0));
    step(0, 0, 1);
    step(0, 0, 0);

`ifdef SEQ_FRAME_PARITY_EN
    send_frame(8'hA6, 1'b0, 1'b1, 1'b1, -1);
    check("parity_good", 64'(parity_err), 64'(0));
    send_frame(8'hA6, 1'b1, 1'b1, 1'b1, -1);
    check("parity_bad", 64'(parity_err), 64'(1));
    repeat (2) step(0, 0, 1);
`endif

    // Reset mid-capture with a held frame present
    send_frame(8'h5A, 1'b1, 1'b0, 1'b0, -1);
    step(1, 1, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    step(0, 1, 0);
    #3;
    rstn = 1'b0;
    #1;
    check("rst_frame_valid", 64'(frame_valid), 64'(0));
    check("rst_frame_data", 64'(frame_data), 64'(0));
    check("rst_frame_drop", 64'(frame_drop), 64'(0));
    check("rst_parity_err", 64'(parity_err), 64'(0));
    model_reset();
    step(0, 0, 0);
    step(0, 0, 0);
    rstn   = 1'b1;
    stream = 12'b1011_0110_1110;
    for (int i = 11; i >= 0; i--) step(0, stream[i], 1);
    repeat (3) step(0, 0, 1);
    check("post_reset_no_frame", 64'(frame_valid), 64'(0));

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 5) == 0, 1'($urandom % 2), ($urandom % 3) != 0);
    end

    repeat (W + 4) step(0, 0, 1);
    check("queue_drained", 64'(exp_q.size()), 64'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
